// File: rtl/cond_unit_it.sv
// ARM-style condition unit with stored NZCV flags, IT-block predication and a
// single saved-flags slot used for exception entry/return.
module cond_unit_it #(
  parameter int FLAG_W      = 4,
  parameter int FLAG_GROUPS = 2,
  parameter int IT_DEPTH    = 4,
  parameter int LW          = $clog2(IT_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             Cond,
  input  logic [FLAG_W-1:0]      ALUFlags,
  input  logic [FLAG_GROUPS-1:0] FlagW,
  input  logic                   PCS,
  input  logic                   NextPC,
  input  logic                   RegW,
  input  logic                   MemW,
  input  logic                   InstrDone,
  input  logic                   ITStart,
  input  logic [LW-1:0]          ITLen,
  input  logic [3:0]             ITCond,
  input  logic [IT_DEPTH-1:0]    ITPattern,
  input  logic                   FlagSave,
  input  logic                   FlagRestore,
  output logic                   PCWrite,
  output logic                   RegWrite,
  output logic                   MemWrite,
  output logic                   CondExQ,
  output logic [FLAG_W-1:0]      Flags,
  output logic                   ITActive,
  output logic [LW-1:0]          ITRemain
);

  localparam int            GW      = FLAG_W / FLAG_GROUPS;
  localparam logic [LW-1:0] MAX_LEN = LW'(IT_DEPTH);
  localparam logic [LW-1:0] ONE     = LW'(1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } itState_e;

  itState_e            state_q, state_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;
  logic [FLAG_W-1:0]   saved_q, saved_d;
  logic                condExQ_q;
  logic [IT_DEPTH-1:0] pattern_q, pattern_d;
  logic [LW-1:0]       remain_q, remain_d;

  logic [3:0] ec;
  logic       condEx;
  logic       flagN, flagZ, flagC, flagV;
  logic       itLenOk;

  assign flagN = flags_q[3];
  assign flagZ = flags_q[2];
  assign flagC = flags_q[1];
  assign flagV = flags_q[0];

  // Inside an IT block pattern bit 0 selects the base condition (then) or its
  // inverse (else); inverting an ARM condition is just flipping its LSB.
  assign ec = (state_q == ACTIVE) ? {ITCond[3:1], ITCond[0] ^ ~pattern_q[0]} : Cond;

  always_comb begin
    condEx = 1'b0;
    unique case (ec)
      4'b0000: condEx = flagZ;
      4'b0001: condEx = ~flagZ;
      4'b0010: condEx = flagC;
      4'b0011: condEx = ~flagC;
      4'b0100: condEx = flagN;
      4'b0101: condEx = ~flagN;
      4'b0110: condEx = flagV;
      4'b0111: condEx = ~flagV;
      4'b1000: condEx = flagC & ~flagZ;
      4'b1001: condEx = ~flagC | flagZ;
      4'b1010: condEx = (flagN == flagV);
      4'b1011: condEx = (flagN != flagV);
      4'b1100: condEx = ~flagZ & (flagN == flagV);
      4'b1101: condEx = flagZ | (flagN != flagV);
      4'b1110: condEx = 1'b1;
      4'b1111: condEx = 1'b0;
      default: condEx = 1'b0;
    endcase
  end

  // Restore overrides any ALU write; save always captures the pre-update flags,
  // so save+restore together naturally swaps the two registers.
  always_comb begin
    flags_d = flags_q;
    if (FlagRestore) begin
      flags_d = saved_q;
    end else begin
      for (int g = 0; g < FLAG_GROUPS; g++) begin
        if (FlagW[g] && condEx) begin
          flags_d[g*GW +: GW] = ALUFlags[g*GW +: GW];
        end
      end
    end
  end

  assign saved_d = FlagSave ? flags_q : saved_q;

  assign itLenOk = (ITLen != '0) && (ITLen <= MAX_LEN);

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    remain_d  = remain_q;
    unique case (state_q)
      IDLE: begin
        if (ITStart && itLenOk) begin
          state_d   = ACTIVE;
          pattern_d = ITPattern;
          remain_d  = ITLen;
        end
      end
      ACTIVE: begin
        if (FlagRestore) begin
          state_d   = IDLE;
          pattern_d = '0;
          remain_d  = '0;
        end else if (InstrDone) begin
          pattern_d = pattern_q >> 1;
          remain_d  = remain_q - ONE;
          if (remain_q == ONE) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      flags_q   <= '0;
      saved_q   <= '0;
      condExQ_q <= 1'b0;
      pattern_q <= '0;
      remain_q  <= '0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      saved_q   <= saved_d;
      condExQ_q <= condEx;
      pattern_q <= pattern_d;
      remain_q  <= remain_d;
    end
  end

  assign PCWrite  = (PCS & condExQ_q) | NextPC;
  assign RegWrite = RegW & condExQ_q;
  assign MemWrite = MemW & condExQ_q;
  assign CondExQ  = condExQ_q;
  assign Flags    = flags_q;
  assign ITActive = (state_q == ACTIVE);
  assign ITRemain = remain_q;

endmodule

// File: doc/cond_unit_it.md
Name: cond_unit_it

Overview:
Parametrised successor to the multicycle ARM condition logic. Evaluates the 4-bit condition field against stored NZCV flags, gates architectural writes (PC, register file, memory) and flag updates, and adds two features: an IT-style predication block covering up to IT_DEPTH following instructions, and one saved-flags slot with save/restore for exception entry and return. Sits between the main microprogram controller and the datapath write enables.

Parameters:
FLAG_W, 4, flag register width; fixed NZCV order, bit 3 = N, bit 0 = V; values other than 4 unsupported.
FLAG_GROUPS, 2, independent flag write groups; group g covers flag bits [(g+1)*FLAG_W/FLAG_GROUPS-1 : g*FLAG_W/FLAG_GROUPS].
IT_DEPTH, 4, maximum instructions predicated by one IT block; range 1..8.
LW, $clog2(IT_DEPTH+1), width of IT length fields.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
Cond  in  4  condition field of current instruction.
ALUFlags  in  FLAG_W  flags produced by ALU this cycle.
FlagW  in  FLAG_GROUPS  per-group flag write request.
PCS, NextPC, RegW, MemW  in  1 each  controller write requests.
InstrDone  in  1  pulse in the final cycle of each instruction.
ITStart  in  1  pulse: open an IT block.
ITLen  in  LW  number of predicated instructions, 1..IT_DEPTH.
ITCond  in  4  base condition of the IT block.
ITPattern  in  IT_DEPTH  bit i = 1: instruction i uses ITCond (then); 0: inverted condition (else).
FlagSave, FlagRestore  in  1 each  save current flags / restore saved flags.
PCWrite, RegWrite, MemWrite  out  1 each  gated write enables.
CondExQ  out  1  registered condition result.
Flags  out  FLAG_W  current flags.
ITActive  out  1  IT block in progress.
ITRemain  out  LW  instructions left in block.

Behaviour:
- Reset (reset low, async): Flags=0, SavedFlags=0, CondExQ=0, ITActive=0, ITRemain=0, pattern register=0. PCWrite/RegWrite/MemWrite follow from those values: PCWrite = NextPC, RegWrite=0, MemWrite=0.
- Effective condition EC. When ITActive=1, EC = {ITCond[3:1], ITCond[0] ^ ~pattern[0]}; otherwise EC = Cond. Cond is ignored while ITActive=1.
- CondEx is combinational from EC and Flags, per the ARM table:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1; 1111 NV 0.
- CondExQ <= CondEx every cycle (one-cycle latency).
- PCWrite = (PCS & CondExQ) | NextPC; RegWrite = RegW & CondExQ; MemWrite = MemW & CondExQ.
- Flag update, group g. Priority order:
  1. FlagRestore: all groups load SavedFlags.
  2. FlagW[g] & CondEx: group g loads ALUFlags.
  3. Otherwise: group holds.
- FlagSave: SavedFlags <= Flags (pre-update value), including when an ALU flag write occurs in the same cycle.
- FlagSave and FlagRestore asserted together: swap (Flags <= old SavedFlags, SavedFlags <= old Flags).
- IT FSM, states IDLE and ACTIVE:
  - IDLE: ITStart with 1<=ITLen<=IT_DEPTH moves to ACTIVE; loads pattern <= ITPattern and ITRemain <= ITLen. ITStart with ITLen=0 or ITLen>IT_DEPTH is ignored.
  - The instruction carrying ITStart is not itself predicated. Its InstrDone in the same cycle does not decrement.
  - ACTIVE: each InstrDone shifts pattern right by 1 (0 in at MSB) and decrements ITRemain. At ITRemain 1->0, return to IDLE and clear ITActive in the same edge.
  - ITStart while ACTIVE is ignored.
  - FlagRestore in ACTIVE aborts the block (return to IDLE, ITRemain=0). This models exception return.
- Reset asserted mid-block clears all state immediately. No partial block is resumed.

Test Plan:
- Flags=0100 (Z=1), Cond=0000, RegW=1 -> RegWrite=1 one cycle after Cond applied; Cond=0001 -> RegWrite=0.
- Cond=1110, FlagW=01, ALUFlags=1011 -> Flags=0011 next edge (only C,V group written). Cond=1111 with same inputs -> Flags unchanged, PCWrite=NextPC only.
- Flags=0100, ITStart with ITLen=3, ITCond=0000, ITPattern=0101, Cond=1110 held:
  - Instr 1: CondExQ=1.
  - Instr 2: CondExQ=0.
  - Instr 3: CondExQ=1.
  - After third InstrDone: ITActive=0, ITRemain=0.
- Flags=1001; FlagSave with FlagW=11, ALUFlags=0110, Cond=AL -> SavedFlags=1001, Flags=0110. Then FlagRestore -> Flags=1001. Both asserted together -> swap.
- ITStart ITLen=0 -> ITActive stays 0. ITStart ITLen=IT_DEPTH+1 -> ignored. ITStart during an active block -> ITRemain unchanged.
- reset driven low asynchronously mid-clock while ITRemain=2 and Flags=1111 -> immediately Flags=0, ITActive=0, RegWrite=0, MemWrite=0, no clock edge required.
